mem_arbiter: RTL and testbench

Two-requester memory arbiter between the instruction fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle NPC core. It grants one shared memory port to one requester at a time, with round-robin fairness, and keeps a single transaction outstanding. Responses go back to the owner, and a response timeout is enforced. It replaces the direct combinational DPI reads for fetch and load with one sequenced valid/ready port in front of the memory model.

---
 rtl/npc_mem_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 19 +
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_mem_pkg.sv
// Shared types and default widths for the NPC core memory path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package npc_mem_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant between IFU (bit 0) and LSU (bit 1).
// Latency: purely combinational.
// Backpressure: none; a tie is broken toward the requester not served last.
module rr_arb2
    import npc_mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output logic [1:0] gnt
);

    // A lone requester always wins; on a tie the last owner yields.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] && (!req[1] || (last_owner == OWN_LSU));
        gnt[1] = req[1] && (!req[0] || (last_owner == OWN_IFU));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction in flight.
// Latency: grant->mem_req_valid 1 cycle; mem_resp_valid->owner resp 1 cycle.
// Backpressure: req_ready only in IDLE; mem_req_ready may stall REQ forever.
module mem_arbiter
    import npc_mem_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_wen,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    localparam int MASK_W = DATA_W / 8;
    // Keep the timer at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT > 0);
    // The timer counts 0,1,.. from the first RESP cycle; the cycle holding
    // TIMEOUT-1 is the last one, so the error pulse lands at h+TIMEOUT+1.
    localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] T_MAX  = '1;

    state_t          state;
    owner_t          last_owner;   // doubles as the owner of the live transaction
    logic [TW-1:0]   timer;
    logic [1:0]      gnt;
    logic            ifu_hs;
    logic            lsu_hs;
    logic            timeout_hit;
    logic [DATA_W-1:0] resp_data;

    rr_arb2 u_rr_arb2 (
        .req        ({lsu_req_valid, ifu_req_valid}),
        .last_owner (last_owner),
        .gnt        (gnt)
    );

    // Ready is only offered while idle, and only to the arbitration winner.
    always_comb begin
        ifu_req_ready = (state == IDLE) && gnt[0];
        lsu_req_ready = (state == IDLE) && gnt[1];
        ifu_hs        = ifu_req_valid && ifu_req_ready;
        lsu_hs        = lsu_req_valid && lsu_req_ready;
        timeout_hit   = TIMEOUT_EN && (timer == T_LAST);
        resp_data     = mem_wen ? '0 : mem_rdata;
        busy          = (state != IDLE);
    end

    // Transaction FSM: payload latch, response timer and response routing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            last_owner     <= OWN_LSU;
            timer          <= '0;
            mem_req_valid  <= 1'b0;
            mem_wen        <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_resp_err   <= 1'b0;
            ifu_rdata      <= '0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_err   <= 1'b0;
            lsu_rdata      <= '0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu_hs) begin
                        last_owner    <= OWN_LSU;
                        mem_wen       <= lsu_wen;
                        mem_addr      <= lsu_addr;
                        mem_wdata     <= lsu_wdata;
                        mem_wmask     <= lsu_wmask;
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end else if (ifu_hs) begin
                        last_owner    <= OWN_IFU;
                        mem_wen       <= 1'b0;
                        mem_addr      <= ifu_addr;
                        mem_wdata     <= '0;
                        mem_wmask     <= {MASK_W{1'b1}};
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        timer         <= '0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    // A real response beats a timeout landing in the same cycle.
                    if (mem_resp_valid || timeout_hit) begin
                        if (last_owner == OWN_IFU) begin
                            ifu_resp_valid <= 1'b1;
                            ifu_resp_err   <= !mem_resp_valid;
                            ifu_rdata      <= mem_resp_valid ? resp_data : '0;
                        end else begin
                            lsu_resp_valid <= 1'b1;
                            lsu_resp_err   <= !mem_resp_valid;
                            lsu_rdata      <= mem_resp_valid ? resp_data : '0;
                        end
                        state <= IDLE;
                    end else if (timer != T_MAX) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with TIMEOUT=4.
// Latency: checks are cycle-exact against hand-computed timing.
// Backpressure: exercises mem_req_ready stalls and requester ties.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr = '0;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        ifu_resp_err;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wmask = '0;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        lsu_resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
        .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Sample 2 time units after the rising edge; inputs are driven from there.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        tick();
        total++;
        if ({ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err, mem_req_valid, mem_wen, busy} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=0000000", {ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err, mem_req_valid, mem_wen, busy});
        end
        total++;
        if ({ifu_rdata, lsu_rdata, mem_addr, mem_wdata, mem_wmask} !== 132'b0) begin
            bad++;
            $display("FAIL reset_data got ifu_rdata=%h lsu_rdata=%h addr=%h wdata=%h wmask=%h exp all 0", ifu_rdata, lsu_rdata, mem_addr, mem_wdata, mem_wmask);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_read;
        ifu_addr = 32'h8000_0000;
        ifu_req_valid = 1'b1;
        #1;
        total++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            bad++;
            $display("FAIL single_ready got=%b exp=10", {ifu_req_ready, lsu_req_ready});
        end
        tick();
        ifu_req_valid = 1'b0;
        total++;
        if ({mem_req_valid, mem_wen, mem_addr, mem_wmask, busy} !== {1'b1, 1'b0, 32'h8000_0000, 4'hF, 1'b1}) begin
            bad++;
            $display("FAIL single_req got v=%b wen=%b addr=%h mask=%h busy=%b exp 1 0 80000000 f 1", mem_req_valid, mem_wen, mem_addr, mem_wmask, busy);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        total++;
        if (mem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_req_drop got=%b exp=0", mem_req_valid);
        end
        tick();
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h0010_0073;
        tick();
        mem_resp_valid = 1'b0;
        total++;
        if ({ifu_resp_valid, ifu_resp_err, lsu_resp_valid, busy, ifu_rdata} !== {4'b1000, 32'h0010_0073}) begin
            bad++;
            $display("FAIL single_resp got v=%b err=%b lsu_v=%b busy=%b data=%h exp 1 0 0 0 00100073", ifu_resp_valid, ifu_resp_err, lsu_resp_valid, busy, ifu_rdata);
        end
        tick();
        total++;
        if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin
            bad++;
            $display("FAIL single_pulse_width got=%b exp=00", {ifu_resp_valid, lsu_resp_valid});
        end
    endtask

    task automatic test_round_robin;
        logic        exp_lsu;
        logic [31:0] exp_addr;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        ifu_addr = 32'h1000_0100;
        lsu_addr = 32'h2000_0200;
        lsu_wen = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        mem_req_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            exp_lsu  = (r % 2) == 1;
            exp_addr = exp_lsu ? 32'h2000_0200 : 32'h1000_0100;
            #1;
            total++;
            if ({ifu_req_ready, lsu_req_ready} !== {!exp_lsu, exp_lsu}) begin
                bad++;
                $display("FAIL rr_grant round=%0d got=%b exp=%b", r, {ifu_req_ready, lsu_req_ready}, {!exp_lsu, exp_lsu});
            end
            tick();
            total++;
            if ({mem_req_valid, mem_addr} !== {1'b1, exp_addr}) begin
                bad++;
                $display("FAIL rr_addr round=%0d got v=%b addr=%h exp 1 %h", r, mem_req_valid, mem_addr, exp_addr);
            end
            tick();
            mem_resp_valid = 1'b1;
            mem_rdata = 32'h100 + r;
            tick();
            mem_resp_valid = 1'b0;
            total++;
            if ({ifu_resp_valid, lsu_resp_valid} !== {!exp_lsu, exp_lsu} ||
                (exp_lsu ? lsu_rdata : ifu_rdata) !== 32'h100 + r) begin
                bad++;
                $display("FAIL rr_resp round=%0d got v=%b ifu=%h lsu=%h exp v=%b data=%h", r, {ifu_resp_valid, lsu_resp_valid}, ifu_rdata, lsu_rdata, {!exp_lsu, exp_lsu}, 32'h100 + r);
            end
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
    endtask

    task automatic test_timeout;
        lsu_wen = 1'b0;
        lsu_addr = 32'h8000_2000;
        lsu_req_valid = 1'b1;
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if ({lsu_resp_valid, busy} !== 2'b01) begin
                bad++;
                $display("FAIL timeout_early cycle=h+%0d got v=%b busy=%b exp 0 1", i, lsu_resp_valid, busy);
            end
            tick();
        end
        total++;
        if ({lsu_resp_valid, lsu_resp_err, ifu_resp_valid, busy, lsu_rdata} !== {4'b1100, 32'h0}) begin
            bad++;
            $display("FAIL timeout_pulse got v=%b err=%b ifu_v=%b busy=%b data=%h exp 1 1 0 0 00000000", lsu_resp_valid, lsu_resp_err, ifu_resp_valid, busy, lsu_rdata);
        end
        ifu_addr = 32'h8000_0040;
        ifu_req_valid = 1'b1;
        #1;
        total++;
        if (ifu_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout_regrant got=%b exp=1", ifu_req_ready);
        end
        tick();
        ifu_req_valid = 1'b0;
        total++;
        if ({mem_req_valid, mem_addr, lsu_resp_valid} !== {1'b1, 32'h8000_0040, 1'b0}) begin
            bad++;
            $display("FAIL timeout_next_req got v=%b addr=%h lsu_v=%b exp 1 80000040 0", mem_req_valid, mem_addr, lsu_resp_valid);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_resp_valid = 1'b0;
        total++;
        if ({ifu_resp_valid, ifu_resp_err, ifu_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
            bad++;
            $display("FAIL timeout_next_resp got v=%b err=%b data=%h exp 1 0 0badf00d", ifu_resp_valid, ifu_resp_err, ifu_rdata);
        end
    endtask

    task automatic test_lsu_write;
        lsu_wen = 1'b1;
        lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF;
        lsu_wmask = 4'hF;
        lsu_req_valid = 1'b1;
        mem_req_ready = 1'b0;
        tick();
        lsu_req_valid = 1'b0;
        lsu_wen = 1'b0;
        lsu_addr = 32'h0;
        lsu_wdata = 32'h0;
        lsu_wmask = 4'h0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask} !== {2'b11, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF}) begin
                bad++;
                $display("FAIL write_hold cycle=%0d got v=%b wen=%b addr=%h wdata=%h mask=%h exp 1 1 80001000 deadbeef f", i, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask);
            end
            if (i == 5) mem_req_ready = 1'b1;
            tick();
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_resp_valid = 1'b0;
        total++;
        if ({lsu_resp_valid, lsu_resp_err, ifu_resp_valid, lsu_rdata} !== {3'b100, 32'h0}) begin
            bad++;
            $display("FAIL write_resp got v=%b err=%b ifu_v=%b data=%h exp 1 0 0 00000000", lsu_resp_valid, lsu_resp_err, ifu_resp_valid, lsu_rdata);
        end
    endtask

    task automatic test_resp_timeout_race;
        ifu_addr = 32'h8000_0010;
        ifu_req_valid = 1'b1;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (ifu_resp_valid !== 1'b0) begin
                bad++;
                $display("FAIL race_early cycle=h+%0d got=%b exp=0", i, ifu_resp_valid);
            end
            if (i == 4) begin
                mem_resp_valid = 1'b1;
                mem_rdata = 32'hCAFE_F00D;
            end
            tick();
        end
        mem_resp_valid = 1'b0;
        total++;
        if ({ifu_resp_valid, ifu_resp_err, busy, ifu_rdata} !== {3'b100, 32'hCAFE_F00D}) begin
            bad++;
            $display("FAIL race_resp got v=%b err=%b busy=%b data=%h exp 1 0 0 cafef00d", ifu_resp_valid, ifu_resp_err, busy, ifu_rdata);
        end
    endtask

    task automatic test_idle_resp;
        tick();
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h0000_0055;
        tick();
        mem_resp_valid = 1'b0;
        total++;
        if ({ifu_resp_valid, lsu_resp_valid, busy, ifu_rdata} !== {3'b000, 32'hCAFE_F00D}) begin
            bad++;
            $display("FAIL idle_resp got v=%b busy=%b ifu_data=%h exp 00 0 cafef00d", {ifu_resp_valid, lsu_resp_valid}, busy, ifu_rdata);
        end
        tick();
        total++;
        if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin
            bad++;
            $display("FAIL idle_resp_late got=%b exp=00", {ifu_resp_valid, lsu_resp_valid});
        end
    endtask

    task automatic test_reset_mid;
        ifu_addr = 32'h8000_0020;
        lsu_addr = 32'h8000_3000;
        ifu_req_valid = 1'b1;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_busy got=%b exp=1", busy);
        end
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h0000_0077;
        tick();
        mem_resp_valid = 1'b0;
        total++;
        if ({ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err, mem_req_valid, mem_wen, busy} !== 7'b0) begin
            bad++;
            $display("FAIL midrst_flags got=%b exp=0000000", {ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err, mem_req_valid, mem_wen, busy});
        end
        total++;
        if ({ifu_rdata, lsu_rdata, mem_addr, mem_wdata, mem_wmask} !== 132'b0) begin
            bad++;
            $display("FAIL midrst_data got ifu_rdata=%h lsu_rdata=%h addr=%h wdata=%h wmask=%h exp all 0", ifu_rdata, lsu_rdata, mem_addr, mem_wdata, mem_wmask);
        end
        rst = 1'b1;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        total++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            bad++;
            $display("FAIL midrst_tie got=%b exp=10", {ifu_req_ready, lsu_req_ready});
        end
        tick();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        total++;
        if ({mem_req_valid, mem_addr} !== {1'b1, 32'h8000_0020}) begin
            bad++;
            $display("FAIL midrst_req got v=%b addr=%h exp 1 80000020", mem_req_valid, mem_addr);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h0000_0099;
        tick();
        mem_resp_valid = 1'b0;
        total++;
        if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== {2'b10, 32'h0000_0099}) begin
            bad++;
            $display("FAIL midrst_resp got v=%b data=%h exp 10 00000099", {ifu_resp_valid, lsu_resp_valid}, ifu_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_lsu_write();
        test_resp_timeout_race();
        test_idle_resp();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #50000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
